// File: rtl/clarvi_mem_arbiter.sv
// rtl/clarvi_mem_arbiter.sv - shares one pipelined Avalon-MM port between fetch and load/store
// Optional contention counter on stat_conflicts: define CLARVI_ARB_STATS_EN.
module clarvi_mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int OUTSTANDING  = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   instr_address,
  input  logic                    instr_read_enable,
  output logic                    instr_wait,
  output logic                    instr_readdatavalid,
  output logic [DATA_WIDTH-1:0]   instr_readdata,
  input  logic [ADDR_WIDTH-1:0]   main_address,
  input  logic [DATA_WIDTH/8-1:0] main_byteenable,
  input  logic                    main_read_enable,
  input  logic                    main_write_enable,
  input  logic [DATA_WIDTH-1:0]   main_writedata,
  output logic                    main_wait,
  output logic                    main_readdatavalid,
  output logic [DATA_WIDTH-1:0]   main_readdata,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH/8-1:0] mem_byteenable,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [DATA_WIDTH-1:0]   mem_writedata,
  input  logic                    mem_waitrequest,
  input  logic                    mem_readdatavalid,
  input  logic [DATA_WIDTH-1:0]   mem_readdata,
  output logic                    resp_error,
  output logic [31:0]             stat_conflicts
);

  localparam int PW = $clog2(OUTSTANDING);
  localparam logic [PW:0] FULL_COUNT = OUTSTANDING[PW:0];
  localparam logic [31:0] STARVE_MAX = STARVE_LIMIT;

  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_M} state_t;

  state_t                 state;
  logic [OUTSTANDING-1:0] tag_mem;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [PW:0]            count;
  logic [31:0]            starve_cnt;
  logic full, forced, instr_live, main_live;
  logic grant_i, grant_m, accept_i, accept_m;
  logic push, pop, head_tag;

  assign full       = (count == FULL_COUNT);
  assign forced     = (STARVE_LIMIT != 0) && (starve_cnt == STARVE_MAX);
  assign instr_live = instr_read_enable && !full;
  assign main_live  = main_write_enable || (main_read_enable && !full);

  // A locked owner keeps the port until its command is accepted; nothing is granted in reset.
  always_comb begin
    grant_i = 1'b0;
    grant_m = 1'b0;
    if (reset_n) begin
      case (state)
        LOCK_I:  grant_i = 1'b1;
        LOCK_M:  grant_m = 1'b1;
        default: begin
          grant_i = instr_live && (!main_live || forced);
          grant_m = main_live && !grant_i;
        end
      endcase
    end
  end

  assign accept_i = grant_i && !mem_waitrequest;
  assign accept_m = grant_m && !mem_waitrequest;

  assign mem_address    = grant_i ? instr_address : main_address;
  assign mem_byteenable = grant_i ? '1 : main_byteenable;
  assign mem_writedata  = main_writedata;
  assign mem_read       = grant_i || (grant_m && main_read_enable);
  assign mem_write      = grant_m && main_write_enable;

  assign instr_wait = !reset_n || (instr_read_enable && !accept_i);
  assign main_wait  = !reset_n || ((main_read_enable || main_write_enable) && !accept_m);

  // Tag 0 = fetch, 1 = load; responses come back in issue order.
  assign push     = accept_i || (accept_m && main_read_enable);
  assign pop      = mem_readdatavalid && (count != '0);
  assign head_tag = tag_mem[rd_ptr];

  assign instr_readdatavalid = pop && !head_tag;
  assign main_readdatavalid  = pop && head_tag;
  assign instr_readdata      = mem_readdata;
  assign main_readdata       = mem_readdata;

  always_ff @(posedge clock) begin
    if (push) tag_mem[wr_ptr] <= accept_m;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      resp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i && mem_waitrequest)      state <= LOCK_I;
          else if (grant_m && mem_waitrequest) state <= LOCK_M;
        end
        default: if (!mem_waitrequest) state <= IDLE;
      endcase
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (!instr_read_enable || accept_i)               starve_cnt <= '0;
      else if (accept_m && starve_cnt != STARVE_MAX)    starve_cnt <= starve_cnt + 1'b1;
      if (mem_readdatavalid && count == '0) resp_error <= 1'b1;
    end
  end

`ifdef CLARVI_ARB_STATS_EN
  logic [31:0] conflicts;

  // Only arbitration losses count, never waitrequest or FIFO-full refusals.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) conflicts <= '0;
    else if (state == IDLE && instr_live && main_live) conflicts <= conflicts + 1'b1;
  end

  assign stat_conflicts = conflicts;
`else
  assign stat_conflicts = '0;
`endif

endmodule

// File: tb/tb_clarvi_mem_arbiter.sv
// tb/tb_clarvi_mem_arbiter.sv - directed and randomized checks for clarvi_mem_arbiter
module tb_clarvi_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int OUT = 4;
  localparam int SL  = 3;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [AW-1:0] instr_address;
  logic          instr_read_enable, instr_wait, instr_readdatavalid;
  logic [DW-1:0] instr_readdata;
  logic [AW-1:0] main_address;
  logic [DW/8-1:0] main_byteenable;
  logic          main_read_enable, main_write_enable, main_wait, main_readdatavalid;
  logic [DW-1:0] main_writedata, main_readdata;
  logic [AW-1:0] mem_address;
  logic [DW/8-1:0] mem_byteenable;
  logic          mem_read, mem_write, mem_waitrequest, mem_readdatavalid;
  logic [DW-1:0] mem_writedata, mem_readdata;
  logic          resp_error;
  logic [31:0]   stat_conflicts;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  clarvi_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTSTANDING(OUT), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .reset_n(reset_n),
    .instr_address(instr_address), .instr_read_enable(instr_read_enable), .instr_wait(instr_wait),
    .instr_readdatavalid(instr_readdatavalid), .instr_readdata(instr_readdata),
    .main_address(main_address), .main_byteenable(main_byteenable), .main_read_enable(main_read_enable),
    .main_write_enable(main_write_enable), .main_writedata(main_writedata), .main_wait(main_wait),
    .main_readdatavalid(main_readdatavalid), .main_readdata(main_readdata),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_waitrequest(mem_waitrequest), .mem_readdatavalid(mem_readdatavalid),
    .mem_readdata(mem_readdata), .resp_error(resp_error), .stat_conflicts(stat_conflicts)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic idle_inputs();
    instr_address = '0; instr_read_enable = 1'b0;
    main_address = '0; main_byteenable = '0; main_read_enable = 1'b0;
    main_write_enable = 1'b0; main_writedata = '0;
    mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0; mem_readdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    instr_read_enable = 1'b1;
    main_write_enable = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    settle();
    checks++; if ({instr_wait, main_wait} !== 2'b11) begin errors++;
      $display("FAIL reset_waits: got %b expected 11", {instr_wait, main_wait}); end
    checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++;
      $display("FAIL reset_mem_cmd: got %b expected 00", {mem_read, mem_write}); end
    checks++; if ({instr_readdatavalid, main_readdatavalid, resp_error} !== 3'b000) begin errors++;
      $display("FAIL reset_valids: got %b expected 000", {instr_readdatavalid, main_readdatavalid, resp_error}); end
    checks++; if (stat_conflicts !== 32'd0) begin errors++;
      $display("FAIL reset_stat: got %0d expected 0", stat_conflicts); end
    idle_inputs();
    next_cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_lone_fetch();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = $urandom;
    d = $urandom;
    do_reset();
    instr_read_enable = 1'b1; instr_address = a;
    settle();
    checks++; if ({mem_read, mem_write, instr_wait} !== 3'b100 || mem_address !== a) begin errors++;
      $display("FAIL lone_fetch_cmd: got rd/wr/wait=%b addr=%h expected 100 addr=%h",
               {mem_read, mem_write, instr_wait}, mem_address, a); end
    next_cycle();
    instr_read_enable = 1'b0;
    settle();
    checks++; if (instr_readdatavalid !== 1'b0) begin errors++;
      $display("FAIL lone_fetch_early: got %b expected 0", instr_readdatavalid); end
    next_cycle();
    mem_readdatavalid = 1'b1; mem_readdata = d;
    settle();
    checks++; if ({instr_readdatavalid, main_readdatavalid} !== 2'b10 || instr_readdata !== d) begin errors++;
      $display("FAIL lone_fetch_resp: got valids=%b data=%h expected 10 data=%h",
               {instr_readdatavalid, main_readdatavalid}, instr_readdata, d); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_starvation();
    int passed_over = 0;
    byte exp_g, got_g;
    logic [31:0] exp_stat;
    do_reset();
    instr_read_enable = 1'b1; instr_address = 32'h100;
    main_write_enable = 1'b1; main_address = 32'h200; main_writedata = 32'h55;
    main_byteenable = 4'hf;
    for (int n = 0; n < 8; n++) begin
      if (passed_over == SL) begin exp_g = "I"; passed_over = 0; end
      else begin exp_g = "M"; passed_over++; end
      settle();
      got_g = mem_read ? "I" : (mem_write ? "M" : "-");
      checks++; if (got_g !== exp_g) begin errors++;
        $display("FAIL starve_order[%0d]: got %c expected %c", n, got_g, exp_g); end
      next_cycle();
      mem_readdatavalid = (got_g == "I");
    end
    instr_read_enable = 1'b0; main_write_enable = 1'b0;
    settle();
`ifdef CLARVI_ARB_STATS_EN
    exp_stat = 32'd8;
`else
    exp_stat = 32'd0;
`endif
    checks++; if (stat_conflicts !== exp_stat) begin errors++;
      $display("FAIL starve_stat: got %0d expected %0d", stat_conflicts, exp_stat); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_lock();
    do_reset();
    main_write_enable = 1'b1; main_address = 32'hcafe0; main_writedata = 32'hdeadbeef;
    main_byteenable = 4'b0101; mem_waitrequest = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin instr_read_enable = 1'b1; instr_address = 32'h1234; end
      settle();
      checks++; if ({mem_write, mem_read, main_wait} !== 3'b101 || mem_address !== 32'hcafe0 ||
                    mem_writedata !== 32'hdeadbeef || mem_byteenable !== 4'b0101) begin errors++;
        $display("FAIL lock_hold[%0d]: got wr/rd/wait=%b addr=%h data=%h be=%b", c,
                 {mem_write, mem_read, main_wait}, mem_address, mem_writedata, mem_byteenable); end
      if (c >= 1) begin
        checks++; if (instr_wait !== 1'b1) begin errors++;
          $display("FAIL lock_instr_wait[%0d]: got %b expected 1", c, instr_wait); end
      end
      next_cycle();
    end
    mem_waitrequest = 1'b0;
    settle();
    checks++; if ({main_wait, mem_write, instr_wait} !== 3'b011) begin errors++;
      $display("FAIL lock_release: got mwait/wr/iwait=%b expected 011", {main_wait, mem_write, instr_wait}); end
    next_cycle();
    main_write_enable = 1'b0;
    settle();
    checks++; if ({mem_read, instr_wait} !== 2'b10 || mem_address !== 32'h1234) begin errors++;
      $display("FAIL lock_next_grant: got rd/wait=%b addr=%h expected 10 addr=1234",
               {mem_read, instr_wait}, mem_address); end
    next_cycle();
    idle_inputs();
    mem_readdatavalid = 1'b1;
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_fifo_full();
    do_reset();
    instr_read_enable = 1'b1;
    for (int n = 0; n < OUT; n++) begin
      instr_address = n;
      settle();
      checks++; if (instr_wait !== 1'b0) begin errors++;
        $display("FAIL fill_accept[%0d]: got %b expected 0", n, instr_wait); end
      next_cycle();
    end
    settle();
    checks++; if ({instr_wait, mem_read} !== 2'b10) begin errors++;
      $display("FAIL full_block: got wait/rd=%b expected 10", {instr_wait, mem_read}); end
    next_cycle();
    mem_readdatavalid = 1'b1;
    settle();
    checks++; if ({instr_wait, instr_readdatavalid} !== 2'b11) begin errors++;
      $display("FAIL full_no_bypass: got wait/valid=%b expected 11", {instr_wait, instr_readdatavalid}); end
    next_cycle();
    mem_readdatavalid = 1'b0;
    settle();
    checks++; if ({instr_wait, mem_read} !== 2'b01) begin errors++;
      $display("FAIL full_reaccept: got wait/rd=%b expected 01", {instr_wait, mem_read}); end
    next_cycle();
    instr_read_enable = 1'b0;
    mem_readdatavalid = 1'b1;
    repeat (OUT) next_cycle();
    idle_inputs();
  endtask

  task automatic test_interleave();
    bit owners[3] = '{1'b0, 1'b1, 1'b0};
    logic [DW-1:0] d;
    do_reset();
    for (int n = 0; n < 3; n++) begin
      instr_read_enable = !owners[n];
      main_read_enable  = owners[n];
      settle();
      checks++; if ({instr_wait, main_wait, mem_read} !== 3'b001) begin errors++;
        $display("FAIL interleave_issue[%0d]: got %b expected 001", n, {instr_wait, main_wait, mem_read}); end
      next_cycle();
    end
    idle_inputs();
    for (int n = 0; n < 3; n++) begin
      d = $urandom;
      mem_readdatavalid = 1'b1; mem_readdata = d;
      settle();
      checks++; if ({instr_readdatavalid, main_readdatavalid} !== {!owners[n], owners[n]} ||
                    (owners[n] ? main_readdata : instr_readdata) !== d) begin errors++;
        $display("FAIL interleave_resp[%0d]: got valids=%b expected %b data %h",
                 n, {instr_readdatavalid, main_readdatavalid}, {!owners[n], owners[n]}, d); end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_resp_error();
    do_reset();
    mem_readdatavalid = 1'b1;
    settle();
    checks++; if ({instr_readdatavalid, main_readdatavalid, resp_error} !== 3'b000) begin errors++;
      $display("FAIL spurious_valid: got %b expected 000", {instr_readdatavalid, main_readdatavalid, resp_error}); end
    next_cycle();
    mem_readdatavalid = 1'b0;
    settle();
    checks++; if (resp_error !== 1'b1) begin errors++;
      $display("FAIL resp_error_set: got %b expected 1", resp_error); end
    repeat (3) next_cycle();
    checks++; if (resp_error !== 1'b1) begin errors++;
      $display("FAIL resp_error_sticky: got %b expected 1", resp_error); end
    reset_n = 1'b0;
    #1;
    checks++; if (resp_error !== 1'b0) begin errors++;
      $display("FAIL resp_error_clear: got %b expected 0", resp_error); end
    next_cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    bit tagq[$];
    bit i_pend = 1'b0, m_pend = 1'b0, m_is_wr = 1'b0;
    int owner_lock = 0;
    int starve = 0;
    int unsigned conf = 0;
    logic [AW-1:0] ia = '0, ma = '0;
    logic [DW-1:0] md = '0;
    logic [DW/8-1:0] mbe = '0;
    logic [31:0] exp_stat;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit ir, mr, mw, wr, rv, full, ilive, mlive, gi, gm, ai, am, owner;
      logic [DW-1:0] rd;
      logic [5:0] exp_f, got_f;
      if (!i_pend && $urandom_range(0, 99) < 50) begin i_pend = 1'b1; ia = $urandom; end
      if (!m_pend && $urandom_range(0, 99) < 50) begin
        m_pend = 1'b1; m_is_wr = 1'($urandom_range(0, 1));
        ma = $urandom; md = $urandom; mbe = 4'($urandom_range(0, 15));
      end
      ir = i_pend; mr = m_pend && !m_is_wr; mw = m_pend && m_is_wr;
      wr = ($urandom_range(0, 99) < 30);
      rv = (tagq.size() != 0) && ($urandom_range(0, 1) == 1);
      rd = $urandom;
      instr_read_enable = ir; instr_address = ia;
      main_read_enable = mr; main_write_enable = mw;
      main_address = ma; main_writedata = md; main_byteenable = mbe;
      mem_waitrequest = wr; mem_readdatavalid = rv; mem_readdata = rd;

      full  = (tagq.size() == OUT);
      ilive = ir && !full;
      mlive = mw || (mr && !full);
      if (owner_lock == 1) begin gi = 1'b1; gm = 1'b0; end
      else if (owner_lock == 2) begin gi = 1'b0; gm = 1'b1; end
      else if (ilive && mlive) begin
        // loads/stores win unless the fetch has already been passed over SL times in a row
        gi = (SL != 0) && (starve == SL);
        gm = !gi;
      end else begin
        gi = ilive; gm = mlive;
      end
      ai = gi && !wr;
      am = gm && !wr;
      owner = rv ? tagq[0] : 1'b0;
      exp_f = {ir && !ai, (mr || mw) && !am, gi || (gm && mr), gm && mw, rv && !owner, rv && owner};

      settle();
      got_f = {instr_wait, main_wait, mem_read, mem_write, instr_readdatavalid, main_readdatavalid};
      checks++; if (got_f !== exp_f) begin errors++;
        $display("FAIL random_flags[%0d]: got %b expected %b", cyc, got_f, exp_f); end
      if (gi || gm) begin
        checks++; if (mem_address !== (gi ? ia : ma)) begin errors++;
          $display("FAIL random_addr[%0d]: got %h expected %h", cyc, mem_address, gi ? ia : ma); end
      end
      if (gm && mw) begin
        checks++; if ({mem_byteenable, mem_writedata} !== {mbe, md}) begin errors++;
          $display("FAIL random_wdata[%0d]: got %h/%h expected %h/%h", cyc, mem_byteenable, mem_writedata, mbe, md); end
      end
      if (rv) begin
        checks++; if ((owner ? main_readdata : instr_readdata) !== rd) begin errors++;
          $display("FAIL random_rdata[%0d]: got %h expected %h", cyc, owner ? main_readdata : instr_readdata, rd); end
      end

      if (owner_lock == 0 && ilive && mlive) conf++;
      if (rv) void'(tagq.pop_front());
      if (ai) tagq.push_back(1'b0);
      if (am && mr) tagq.push_back(1'b1);
      if (owner_lock == 0) begin
        if (gi && wr) owner_lock = 1;
        else if (gm && wr) owner_lock = 2;
      end else if (!wr) owner_lock = 0;
      if (!ir || ai) starve = 0;
      else if (am && starve < SL) starve++;
      if (ai) i_pend = 1'b0;
      if (am) m_pend = 1'b0;
      next_cycle();
    end
    idle_inputs();
    while (tagq.size() != 0) begin
      mem_readdatavalid = 1'b1;
      void'(tagq.pop_front());
      next_cycle();
    end
    idle_inputs();
    settle();
`ifdef CLARVI_ARB_STATS_EN
    exp_stat = conf;
`else
    exp_stat = 32'd0;
`endif
    checks++; if (stat_conflicts !== exp_stat) begin errors++;
      $display("FAIL random_stat: got %0d expected %0d", stat_conflicts, exp_stat); end
    checks++; if (resp_error !== 1'b0) begin errors++;
      $display("FAIL random_resp_error: got %b expected 0", resp_error); end
    next_cycle();
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b1;
    #2;
    test_reset();
    test_lone_fetch();
    test_starvation();
    test_lock();
    test_fifo_full();
    test_interleave();
    test_resp_error();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
